pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
- Central hazard and flow-control unit for the NeoCore 16x32 5-stage pipeline.
- Drives the stall/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers, plus PC hold/redirect.
- Resolves load-use hazards, taken-branch flushes, multi-cycle memory waits and halt draining.
- Keeps saturating performance counters.

Parameters:
LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (1..3); 1 means MEM->EX forwarding is present.
CNT_W, 32, width of performance counters.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  valid instruction in ID
id_rs1_addr  in  4  ID source 1
id_rs2_addr  in  4  ID source 2
id_rs1_used  in  1  ID reads rs1
id_rs2_used  in  1  ID reads rs2
ex_valid  in  1  valid instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_rd_addr  in  4  EX destination
ex_rd_we  in  1  EX writes rd
ex_branch_taken  in  1  EX resolved a taken branch/JSR/RTS
ex_is_halt  in  1  HLT in EX
wb_is_halt  in  1  HLT valid in WB
mem_busy  in  1  data memory not ready; MEM must hold
resume  in  1  leave HALTED
pc_stall  out  1  hold PC
pc_redirect  out  1  load PC from branch target
stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb  out  1 each  stage-register stalls
flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb  out  1 each  stage-register flushes
halted  out  1  core halted
perf_stall_cycles  out  CNT_W  cycles with pc_stall high
perf_flush_count  out  CNT_W  number of branch-redirect events

Behaviour:
- States: RUN, LU_STALL, HALTING, HALTED. Bubble counter lu_cnt is 2 bits.
- Reset (rst_n low, asynchronous): state RUN, lu_cnt 0, both counters 0, halted 0. All stall/flush/pc outputs are combinational and therefore 0 in RUN with idle inputs.
- Outputs are combinational from state and inputs; state and counters change on the rising clk edge. Zero-cycle decision latency.
- Priority, highest first: mem_busy > halt > branch > load-use.
- mem_busy (any state except HALTED):
  - pc_stall and all four stage stalls are 1; all flushes are 0.
  - State and lu_cnt are frozen.
  - An EX branch or halt is held and acted on in the first cycle mem_busy is low.
- RUN, ex_is_halt & ex_valid:
  - pc_stall=1, flush_if_id=1, flush_id_ex=1.
  - Go to HALTING.
- RUN, ex_branch_taken & ex_valid:
  - pc_redirect=1, flush_if_id=1, flush_id_ex=1.
  - Increment perf_flush_count.
  - Any load-use hazard seen in the same cycle is ignored (wrong-path instruction).
- RUN, load-use:
  - Hazard condition: id_valid & ex_valid & ex_mem_read & ex_rd_we & ex_rd_addr matches a used ID source.
  - Actions: pc_stall=1, stall_if_id=1, flush_id_ex=1.
  - If LOAD_USE_BUBBLES>1: lu_cnt<=LOAD_USE_BUBBLES-1 and go to LU_STALL; otherwise stay in RUN.
  - Register 0 is a normal register and does take part in hazard detection.
- LU_STALL:
  - Outputs: pc_stall=1, stall_if_id=1, flush_id_ex=1.
  - lu_cnt decrements each cycle; at lu_cnt==1 return to RUN.
  - Branch/halt cannot appear in EX here because EX holds a bubble.
- HALTING:
  - Outputs: pc_stall=1, stall_if_id=1, flush_id_ex=1; older instructions drain.
  - On wb_is_halt go to HALTED.
- HALTED:
  - pc_stall and all stage stalls are 1; halted=1; mem_busy is ignored.
  - On resume go to RUN with halted=0 next cycle.
  - PC restarts at the instruction after HLT; the PC unit owns that value.
- perf_stall_cycles increments each cycle pc_stall=1 in any state except HALTED.
- Both counters saturate at all-ones and never wrap.
- Flush and stall are never asserted together for the same register. If they collide, flush wins in the output logic.
- Reset asserted mid-stall or mid-halt returns immediately to RUN with zeroed counters.

Decomposition:
- neocore_pkg gets:
  - ctrl_state_t enum (RUN, LU_STALL, HALTING, HALTED);
  - a pipe_ctrl_t struct bundling the four stall and four flush bits;
  - the constant LU_MAX=3.
- One natural sub-module: perf_counter_sat (CNT_W-bit saturating incrementer with async active-low reset), instantiated twice.

Test Plan:
- LDR R3 in EX (ex_mem_read=1, ex_rd_addr=3), ID reads rs1=3, LOAD_USE_BUBBLES=1 -> exactly 1 cycle of pc_stall=1, stall_if_id=1, flush_id_ex=1; perf_stall_cycles=1.
- Same hazard, LOAD_USE_BUBBLES=3 -> 3 consecutive stall cycles, state LU_STALL for 2 cycles, then RUN; perf_stall_cycles=3.
- ex_branch_taken=1 together with a load-use match -> pc_redirect=1, flush_if_id=1, flush_id_ex=1, pc_stall=0; perf_flush_count=1.
- ex_branch_taken=1 while mem_busy=1 for 4 cycles -> all stalls high and no redirect for 4 cycles; redirect in cycle 5.
- ex_is_halt=1, wb_is_halt two cycles later -> HALTING for 2 cycles, then halted=1 with all stalls high; resume=1 -> halted=0 next cycle.
- Force perf_stall_cycles to 0xFFFF_FFFF, then stall again -> value stays 0xFFFF_FFFF; assert rst_n=0 in LU_STALL -> state RUN and counters 0 with no clock edge.

Source files
------------

// File: rtl/neocore_pkg.sv
// Shared types and constants for the NeoCore pipeline control slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package neocore_pkg;

  // Upper bound on load-use bubbles the bubble counter can express.
  localparam int LU_MAX = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    HALTING  = 2'd2,
    HALTED   = 2'd3
  } ctrl_state_t;

  // Stall and flush controls for the four stage registers.
  typedef struct packed {
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic stall_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
    logic flush_mem_wb;
  } pipe_ctrl_t;

endpackage

// File: rtl/perf_counter_sat.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
// Latency: count visible the cycle after the inc edge.
// Backpressure: none; inc is sampled every cycle.
// Ports: clk, rst_n (async active-low), inc (count enable), cnt (current value).
module perf_counter_sat #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/flow-control unit for the NeoCore 5-stage pipeline: stalls, flushes, PC hold/redirect, halt.
// Latency: zero-cycle decisions (outputs combinational from state and inputs); state updates on clk.
// Backpressure: mem_busy freezes the whole pipe and this FSM; pending branch/halt is acted on once it drops.
// Ports: ID/EX hazard info, EX branch/halt, WB halt, mem_busy, resume in;
//        pc_stall/pc_redirect, per-stage stall/flush, halted, two perf counters out.
module pipeline_ctrl
  import neocore_pkg::*;
#(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [3:0]       id_rs1_addr,
  input  logic [3:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [3:0]       ex_rd_addr,
  input  logic             ex_rd_we,
  input  logic             ex_branch_taken,
  input  logic             ex_is_halt,
  input  logic             wb_is_halt,
  input  logic             mem_busy,
  input  logic             resume,
  output logic             pc_stall,
  output logic             pc_redirect,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             stall_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             flush_mem_wb,
  output logic             halted,
  output logic [CNT_W-1:0] perf_stall_cycles,
  output logic [CNT_W-1:0] perf_flush_count
);

  // Out-of-range bubble counts are clamped to what the 2-bit counter can hold.
  localparam int          LU_BUB    = (LOAD_USE_BUBBLES > LU_MAX) ? LU_MAX :
                                      (LOAD_USE_BUBBLES < 1) ? 1 : LOAD_USE_BUBBLES;
  localparam logic [1:0]  LU_RELOAD = 2'(LU_BUB - 1);
  localparam logic        LU_MULTI  = (LU_BUB > 1);

  ctrl_state_t state;
  logic [1:0]  lu_cnt;
  pipe_ctrl_t  raw;
  logic        halt_req, br_req, lu_hazard;

  assign halt_req  = ex_valid & ex_is_halt;
  assign br_req    = ex_valid & ex_branch_taken;
  // R0 is an ordinary register here, so no zero-address exclusion.
  assign lu_hazard = id_valid & ex_valid & ex_mem_read & ex_rd_we &
                     ((id_rs1_used & (id_rs1_addr == ex_rd_addr)) |
                      (id_rs2_used & (id_rs2_addr == ex_rd_addr)));

  always_comb begin
    raw         = '0;
    pc_stall    = 1'b0;
    pc_redirect = 1'b0;
    if (state == HALTED || mem_busy) begin
      // Full freeze; in HALTED mem_busy is irrelevant, the result is the same.
      pc_stall         = 1'b1;
      raw.stall_if_id  = 1'b1;
      raw.stall_id_ex  = 1'b1;
      raw.stall_ex_mem = 1'b1;
      raw.stall_mem_wb = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (halt_req) begin
            pc_stall        = 1'b1;
            raw.flush_if_id = 1'b1;
            raw.flush_id_ex = 1'b1;
          end else if (br_req) begin
            // The ID instruction is wrong-path, so its hazard is moot.
            pc_redirect     = 1'b1;
            raw.flush_if_id = 1'b1;
            raw.flush_id_ex = 1'b1;
          end else if (lu_hazard) begin
            pc_stall        = 1'b1;
            raw.stall_if_id = 1'b1;
            raw.flush_id_ex = 1'b1;
          end
        end
        LU_STALL, HALTING: begin
          pc_stall        = 1'b1;
          raw.stall_if_id = 1'b1;
          raw.flush_id_ex = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A flush always overrides a stall on the same register.
  assign stall_if_id  = raw.stall_if_id  & ~raw.flush_if_id;
  assign stall_id_ex  = raw.stall_id_ex  & ~raw.flush_id_ex;
  assign stall_ex_mem = raw.stall_ex_mem & ~raw.flush_ex_mem;
  assign stall_mem_wb = raw.stall_mem_wb & ~raw.flush_mem_wb;
  assign flush_if_id  = raw.flush_if_id;
  assign flush_id_ex  = raw.flush_id_ex;
  assign flush_ex_mem = raw.flush_ex_mem;
  assign flush_mem_wb = raw.flush_mem_wb;
  assign halted       = (state == HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      lu_cnt <= 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (!mem_busy) begin
            if (halt_req) begin
              state <= HALTING;
            end else if (!br_req && lu_hazard && LU_MULTI) begin
              lu_cnt <= LU_RELOAD;
              state  <= LU_STALL;
            end
          end
        end
        LU_STALL: begin
          if (!mem_busy) begin
            lu_cnt <= lu_cnt - 2'd1;
            if (lu_cnt == 2'd1) state <= RUN;
          end
        end
        HALTING: begin
          if (!mem_busy && wb_is_halt) state <= HALTED;
        end
        HALTED: begin
          if (resume) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  perf_counter_sat #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_stall & (state != HALTED)),
    .cnt   (perf_stall_cycles)
  );

  perf_counter_sat #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_redirect),
    .cnt   (perf_flush_count)
  );

endmodule
